// File: rtl/pipeline_alu_fwd.sv
// pipeline_alu_fwd: ID/EX/WB register-file ALU pipeline, Out two edges after issue, stall freezes all state.
// Optional operand forwarding from EX and WB into ID is built when PIPELINE_ALU_FWD_EN is defined.
module pipeline_alu_fwd #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       InstrIn,
  input  logic              in_valid,
  input  logic              stall,
  output logic [DATA_W-1:0] Out,
  output logic              out_valid,
  output logic [4:0]        out_dst
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [5:0] OP_ADD = 6'd0;
  localparam logic [5:0] OP_SUB = 6'd1;
  localparam logic [5:0] OP_AND = 6'd2;
  localparam logic [5:0] OP_OR  = 6'd3;
  localparam logic [5:0] OP_XOR = 6'd4;
  localparam logic [5:0] OP_SLT = 6'd5;

  logic [DATA_W-1:0] rf [NUM_REGS];

  logic              id_vld;
  logic [20:0]       id_instr;
  logic              ex_vld;
  logic              ex_wr;
  logic [5:0]        ex_op;
  logic [4:0]        ex_dst;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;

  logic [5:0]        id_op;
  logic [4:0]        id_srca;
  logic [4:0]        id_srcb;
  logic [4:0]        id_dst;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic [DATA_W-1:0] alu_res;
  logic              unused_instr_bits;

  assign unused_instr_bits = ^InstrIn[10:0];

  assign id_op   = id_instr[20:15];
  assign id_srca = id_instr[14:10];
  assign id_srcb = id_instr[9:5];
  assign id_dst  = id_instr[4:0];

  // R0 and indices beyond NUM_REGS are hardwired zero and never written
  function automatic logic in_range(input logic [4:0] idx);
    return (idx != 5'd0) && (int'(idx) < NUM_REGS);
  endfunction

  function automatic logic is_alu(input logic [5:0] op);
    return op <= OP_SLT;
  endfunction

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (in_range(id_srca)) rd_a = rf[id_srca[AW-1:0]];
    if (in_range(id_srcb)) rd_b = rf[id_srcb[AW-1:0]];
  end

  always_comb begin
    opa = rd_a;
    opb = rd_b;
`ifdef PIPELINE_ALU_FWD_EN
    if (out_valid && in_range(out_dst)) begin
      if (out_dst == id_srca) opa = Out;
      if (out_dst == id_srcb) opb = Out;
    end
    // EX is the younger producer, so it overrides WB
    if (ex_vld && ex_wr && in_range(ex_dst)) begin
      if (ex_dst == id_srca) opa = alu_res;
      if (ex_dst == id_srcb) opb = alu_res;
    end
`endif
  end

  always_comb begin
    alu_res = '0;
    case (ex_op)
      OP_ADD:  alu_res = ex_a + ex_b;
      OP_SUB:  alu_res = ex_a - ex_b;
      OP_AND:  alu_res = ex_a & ex_b;
      OP_OR:   alu_res = ex_a | ex_b;
      OP_XOR:  alu_res = ex_a ^ ex_b;
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(ex_a) < $signed(ex_b))};
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      id_vld    <= 1'b0;
      id_instr  <= '0;
      ex_vld    <= 1'b0;
      ex_wr     <= 1'b0;
      ex_op     <= '0;
      ex_dst    <= '0;
      ex_a      <= '0;
      ex_b      <= '0;
      Out       <= '0;
      out_valid <= 1'b0;
      out_dst   <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= DATA_W'(i);
    end else if (!stall) begin
      id_vld    <= in_valid;
      id_instr  <= InstrIn[31:11];
      ex_vld    <= id_vld;
      ex_wr     <= id_vld && is_alu(id_op);
      ex_op     <= id_op;
      ex_dst    <= id_dst;
      ex_a      <= opa;
      ex_b      <= opb;
      Out       <= (ex_vld && ex_wr) ? alu_res : '0;
      out_valid <= ex_vld && ex_wr;
      out_dst   <= ex_dst;
      if (out_valid && in_range(out_dst)) rf[out_dst[AW-1:0]] <= Out;
    end
  end

endmodule

// File: tb/tb_pipeline_alu_fwd.sv
// Scoreboard bench for pipeline_alu_fwd at DATA_W=8, NUM_REGS=8; an ISA-level register model
// with a three-slot commit delay line predicts each WB result, with or without PIPELINE_ALU_FWD_EN.
module tb_pipeline_alu_fwd;
  localparam int DW = 8;
  localparam int NR = 8;

  logic          clk;
  logic          rst;
  logic [31:0]   instr;
  logic          in_valid;
  logic          stall;
  logic [DW-1:0] out;
  logic          out_valid;
  logic [4:0]    out_dst;

  pipeline_alu_fwd #(.DATA_W(DW), .NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst), .InstrIn(instr), .in_valid(in_valid), .stall(stall),
    .Out(out), .out_valid(out_valid), .out_dst(out_dst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          vld;
    logic [4:0]    dst;
    logic [DW-1:0] val;
  } ent_t;

  ent_t          sbq[$];
  ent_t          pend [3];
  logic [DW-1:0] seq_rf [NR];
  logic [DW-1:0] com_rf [NR];
  int            n_chk;
  int            n_fail;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit wr_ok(input logic [4:0] idx);
    return idx != 5'd0 && int'(idx) < NR;
  endfunction

  function automatic logic [DW-1:0] mread(input logic [4:0] idx);
    if (!wr_ok(idx)) return '0;
`ifdef PIPELINE_ALU_FWD_EN
    return seq_rf[int'(idx)];
`else
    return com_rf[int'(idx)];
`endif
  endfunction

  function automatic logic [DW-1:0] alu_m(input logic [5:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      6'd0:    return a + b;
      6'd1:    return a - b;
      6'd2:    return a & b;
      6'd3:    return a | b;
      6'd4:    return a ^ b;
      6'd5:    return (signed'(a) < signed'(b)) ? DW'(1) : DW'(0);
      default: return '0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      seq_rf[i] = DW'(i);
      com_rf[i] = DW'(i);
    end
    for (int i = 0; i < 3; i++) pend[i] = '0;
    sbq.delete();
  endtask

  task automatic do_reset(input bit with_stall);
    rst      = 1'b0;
    stall    = with_stall;
    in_valid = 1'b1;
    instr    = $urandom;
    @(posedge clk); #1;
    rst   = 1'b1;
    stall = 1'b0;
    model_reset();
    check_eq("rst_out", out, 0);
    check_eq("rst_vld", out_valid, 0);
    check_eq("rst_dst", out_dst, 0);
  endtask

  task automatic issue(input bit v, input logic [5:0] op, input logic [4:0] a,
                       input logic [4:0] b, input logic [4:0] d);
    ent_t e;
    logic [DW-1:0] res;
    bit wr;
    if (pend[2].vld && wr_ok(pend[2].dst)) com_rf[int'(pend[2].dst)] = pend[2].val;
    pend[2] = pend[1];
    pend[1] = pend[0];
    wr  = v && (op <= 6'd5);
    res = alu_m(op, mread(a), mread(b));
    if (wr && wr_ok(d)) seq_rf[int'(d)] = res;
    pend[0] = '{vld: wr, dst: d, val: res};
    sbq.push_back('{vld: wr, dst: d, val: wr ? res : '0});

    in_valid = v;
    stall    = 1'b0;
    instr    = {op, a, b, d, 11'h5a5};
    @(posedge clk); #1;
    if (sbq.size() == 3) begin
      e = sbq.pop_front();
      check_eq("wb_vld", out_valid, e.vld);
      if (e.vld) begin
        check_eq("wb_out", out, e.val);
        check_eq("wb_dst", out_dst, e.dst);
      end
    end else begin
      check_eq("fill_vld", out_valid, 0);
    end
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic stall_for(input int n);
    logic [DW-1:0] o;
    logic          v;
    logic [4:0]    d;
    o = out;
    v = out_valid;
    d = out_dst;
    stall    = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      instr = $urandom;
      @(posedge clk); #1;
      check_eq("stall_out", out, o);
      check_eq("stall_vld", out_valid, v);
      check_eq("stall_dst", out_dst, d);
    end
    stall = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    rst      = 1'b0;
    stall    = 1'b0;
    in_valid = 1'b0;
    instr    = '0;
    @(posedge clk); #1;
    do_reset(1'b0);

    // single ADD 2,1->2 gives 3, then R2 reads back 3
    issue(1, 6'd0, 5'd2, 5'd1, 5'd2);
    bubbles(3);
    issue(1, 6'd3, 5'd2, 5'd0, 5'd3);
    bubbles(3);

    // dependent ADD pairs at distance 1, 2 and 3
    for (int gap = 0; gap < 3; gap++) begin
      do_reset(1'b0);
      issue(1, 6'd0, 5'd2, 5'd1, 5'd2);
      bubbles(gap);
      issue(1, 6'd0, 5'd2, 5'd1, 5'd2);
      bubbles(3);
    end

    // SUB wraps to 8'hFE, SLT treats it as -2
    do_reset(1'b0);
    issue(1, 6'd1, 5'd1, 5'd3, 5'd5);
    bubbles(2);
    issue(1, 6'd5, 5'd5, 5'd1, 5'd6);
    bubbles(3);

    // stall mid-stream, then bubble
    issue(1, 6'd0, 5'd3, 5'd4, 5'd1);
    issue(1, 6'd4, 5'd6, 5'd7, 5'd2);
    issue(1, 6'd2, 5'd5, 5'd7, 5'd3);
    stall_for(3);
    issue(1, 6'd0, 5'd1, 5'd2, 5'd4);
    issue(0, 6'd0, 5'd1, 5'd1, 5'd1);
    bubbles(3);

    // reset while three writers of R2 are in flight, asserted together with stall
    issue(1, 6'd0, 5'd2, 5'd1, 5'd2);
    issue(1, 6'd0, 5'd2, 5'd1, 5'd2);
    issue(1, 6'd0, 5'd2, 5'd1, 5'd2);
    do_reset(1'b1);
    issue(1, 6'd3, 5'd2, 5'd0, 5'd7);
    bubbles(3);

    // R0, out-of-range R9 and an undefined opcode all leave the register file alone
    issue(1, 6'd0, 5'd1, 5'd2, 5'd0);
    issue(1, 6'd0, 5'd3, 5'd4, 5'd9);
    issue(1, 6'h3f, 5'd1, 5'd2, 5'd3);
    bubbles(3);
    issue(1, 6'd0, 5'd0, 5'd0, 5'd5);
    issue(1, 6'd3, 5'd9, 5'd0, 5'd6);
    issue(1, 6'd3, 5'd3, 5'd0, 5'd7);
    bubbles(3);

    // random traffic with bubbles, stalls and NOPs
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) stall_for($urandom_range(1, 3));
      issue($urandom_range(0, 4) != 0, 6'($urandom_range(0, 7)), 5'($urandom_range(0, 9)),
            5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)));
    end
    bubbles(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_alu_fwd.md
# pipeline_alu_fwd

Parametrised 3-stage register-file/ALU pipeline: decode and operand read, execute, writeback. It is the next generation of the single-op pipeline datapath. It accepts one R-type instruction per cycle and adds selectable ALU ops, configurable data width and register count, a valid/stall handshake, and compile-time operand forwarding. It is the execution core that the lab CPU datapath feeds from its instruction source.

## Interface
Parameters:
- DATA_W, 32, datapath and register width in bits (8..64).
- NUM_REGS, 32, architectural register count; power of 2, 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset, sampled on rising clk.
- InstrIn  input  32  instruction: [31:26] op, [25:21] srcA, [20:16] srcB, [15:11] dst, [10:0] ignored.
- in_valid  input  1  InstrIn is valid this cycle.
- stall  input  1  freeze whole pipeline, including the register file, this cycle.
- Out  output  DATA_W  result of the instruction in the WB stage.
- out_valid  output  1  Out holds a writing instruction's result.
- out_dst  output  5  destination index of the WB instruction.

## Operation
- Register file:
  - R0 always reads 0; writes to R0 are dropped.
  - Any index ≥ NUM_REGS reads 0 and writes to it are dropped.
  - On reset, R[i] = i, truncated to DATA_W, for 1 ≤ i < NUM_REGS.
- Op codes:
  - 000000 ADD: A+B.
  - 000001 SUB: A−B.
  - 000010 AND.
  - 000011 OR.
  - 000100 XOR.
  - 000101 SLT: signed A<B gives 1, else 0, zero-extended.
  - Any other op is a NOP: it flows down the pipe but writes nothing and does not set out_valid.
- Arithmetic is modulo 2^DATA_W. No overflow flag.
- Stages:
  - ID: holds the latched instruction and reads the operands.
  - EX: registered operands, combinational ALU.
  - WB: registered result. Out, out_valid and out_dst are driven from WB. The register file is written at the edge that leaves WB.
- A stage advances only when stall=0. A bubble, i.e. in_valid=0 sampled into ID, propagates as an invalid stage.
- Reset (rst=0):
  - All stage valid bits clear.
  - Out = 0, out_valid = 0, out_dst = 0.
  - Register file reinitialised.
  - Applies mid-stream too: in-flight instructions are discarded and never written.

## Timing
- Instruction sampled at edge N:
  - in EX after N+1;
  - Out/out_valid after N+2;
  - register file updated at N+3.
- Throughput is 1 instruction/cycle. No internal hazard stalls.
- stall=1 holds every register (stage, Out, out_valid, register file) unchanged. InstrIn is ignored that cycle.
- Stall then reset in the same cycle: reset wins.
- Without forwarding, a consumer issued at N+1 or N+2 of its producer reads stale values. From N+3 onward it reads the new value.

## Configuration
- Macro: PIPELINE_ALU_FWD_EN.
- Defined:
  - ID operand read prioritises the EX-stage ALU output when EX is valid and writing the same nonzero, in-range dst.
  - Next priority is the WB result, then the register file.
  - A dependent instruction at any distance sees the correct value.
- Undefined: operands come only from the register file, so hazards must be scheduled by software.
- The same-cycle WB write and ID read collision at N+3 is resolved by write-first register-file read in both builds.

## Test plan
- Reset, then ADD srcA=2 srcB=1 dst=2 -> Out=3, out_valid=1, out_dst=2 two edges later; R2=3 afterward.
- Back-to-back ADD 2,1→2 twice:
  - with PIPELINE_ALU_FWD_EN, second Out=4;
  - without it, second Out=3.
  - Repeat with one and two bubbles between the two instructions; with forwarding, second Out=4 in both cases.
- SUB 1,3→5 with DATA_W=8 -> Out=8'hFE. SLT 5,1→6 afterward -> 1 (−2<1 signed).
- stall=1 for 3 cycles mid-stream -> Out, out_valid and out_dst frozen; sequence resumes with results unchanged. in_valid=0 -> out_valid=0 two edges later.
- rst=0 asserted while 3 instructions are in flight -> no register written (R2 reads 2 after reset); Out=0, out_valid=0.
- Writes to R0 and, with NUM_REGS=8, to R9 -> later reads return 0; op 111111 -> no write, out_valid=0.
